// File: rtl/vga_fx_pkg.sv
// Shared types and constants for the post-mux video effects stage.
// Holds the fade FSM state encoding and the channel scaling helper.
package vga_fx_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FADE_OUT,
    BLACK,
    FADE_IN
  } fade_state_t;

  localparam logic [4:0] LEVEL_MAX = 5'd16;
  localparam logic [7:0] FLASH_RED = 8'hFF;

  // (ch * level) >> 4 with level in 0..16; 255 * 16 >> 4 still fits in 8 bits.
  function automatic logic [7:0] scale_channel(input logic [7:0] ch, input logic [4:0] level);
    logic [12:0] prod;
    prod = 13'(ch) * 13'(level);
    return 8'(prod >> 4);
  endfunction

endpackage

// File: rtl/rgb332_scaler.sv
// Combinational RGB332 -> 24-bit expansion (LSB replicated) followed by
// brightness scaling by a 0..16 level.
module rgb332_scaler
  import vga_fx_pkg::*;
(
  input  logic [7:0]  pixel_i,
  input  logic [4:0]  level_i,
  output logic [23:0] rgb_o
);

  logic [7:0] ch8 [3];

  assign ch8[0] = {pixel_i[7:5], {5{pixel_i[5]}}};
  assign ch8[1] = {pixel_i[4:2], {5{pixel_i[2]}}};
  assign ch8[2] = {pixel_i[1:0], {6{pixel_i[0]}}};

  // rgb_o is packed {R, G, B}; channel gi lands in the gi-th byte from the top.
  for (genvar gi = 0; gi < 3; gi++) begin : g_ch
    assign rgb_o[23 - 8*gi -: 8] = scale_channel(ch8[gi], level_i);
  end

endmodule

// File: rtl/screen_fade_fx.sv
// Post-mux effects stage: frame-synchronous fade-out / black / fade-in and a
// blinking red hit flash, with registered 8-bit-per-channel DAC outputs.
module screen_fade_fx
  import vga_fx_pkg::*;
#(
  parameter int FRAMES_PER_STEP = 2,
  parameter int BLACK_FRAMES    = 30,
  parameter int FLASH_FRAMES    = 8
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       fadeRequest,
  input  logic       hitFlash,
  input  logic [7:0] pixelRGB,
  output logic [7:0] redOut,
  output logic [7:0] greenOut,
  output logic [7:0] blueOut,
  output logic       fadeBusy,
  output logic       screenBlack
);

  localparam int CNT_MAX = (FRAMES_PER_STEP > BLACK_FRAMES) ? FRAMES_PER_STEP : BLACK_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int FLASH_W = $clog2(FLASH_FRAMES + 1);

  localparam logic [CNT_W-1:0]   STEP_LAST  = CNT_W'(FRAMES_PER_STEP - 1);
  localparam logic [CNT_W-1:0]   BLACK_LAST = CNT_W'(BLACK_FRAMES - 1);
  localparam logic [FLASH_W-1:0] FLASH_INIT = FLASH_W'(FLASH_FRAMES);

  fade_state_t        state_q, state_d;
  logic [4:0]         level_q, level_d;
  logic [CNT_W-1:0]   frame_cnt_q, frame_cnt_d;
  logic [FLASH_W-1:0] flash_cnt_q, flash_cnt_d;
  logic               screen_black_q, screen_black_d;
  logic [7:0]         red_q, green_q, blue_q;
  logic [23:0]        scaled_rgb;
  logic               flash_on;

  rgb332_scaler u_scaler (
    .pixel_i (pixelRGB),
    .level_i (level_q),
    .rgb_o   (scaled_rgb)
  );

  always_comb begin
    state_d     = state_q;
    level_d     = level_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      IDLE: begin
        level_d = LEVEL_MAX;
        if (fadeRequest) begin
          state_d     = FADE_OUT;
          frame_cnt_d = '0;
        end
      end
      FADE_OUT: begin
        if (startOfFrame) begin
          if (frame_cnt_q >= STEP_LAST) begin
            frame_cnt_d = '0;
            if (level_q != 5'd0) level_d = level_q - 5'd1;
            if (level_q <= 5'd1) state_d = BLACK;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      BLACK: begin
        if (startOfFrame) begin
          if (frame_cnt_q >= BLACK_LAST) begin
            frame_cnt_d = '0;
            state_d     = FADE_IN;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      FADE_IN: begin
        if (startOfFrame) begin
          if (frame_cnt_q >= STEP_LAST) begin
            frame_cnt_d = '0;
            if (level_q < LEVEL_MAX) level_d = level_q + 5'd1;
            if (level_q >= LEVEL_MAX - 5'd1) state_d = IDLE;
          end else begin
            frame_cnt_d = frame_cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign screen_black_d = (state_d == BLACK) && (state_q != BLACK);

  // A hitFlash load takes priority over the frame decrement in the same cycle.
  always_comb begin
    flash_cnt_d = flash_cnt_q;
    if (hitFlash) begin
      flash_cnt_d = FLASH_INIT;
    end else if (startOfFrame && (flash_cnt_q != '0)) begin
      flash_cnt_d = flash_cnt_q - FLASH_W'(1);
    end
  end

  assign flash_on = (flash_cnt_q != '0) && flash_cnt_q[0];

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q        <= IDLE;
      level_q        <= LEVEL_MAX;
      frame_cnt_q    <= '0;
      flash_cnt_q    <= '0;
      screen_black_q <= 1'b0;
      red_q          <= 8'h00;
      green_q        <= 8'h00;
      blue_q         <= 8'h00;
    end else begin
      state_q        <= state_d;
      level_q        <= level_d;
      frame_cnt_q    <= frame_cnt_d;
      flash_cnt_q    <= flash_cnt_d;
      screen_black_q <= screen_black_d;
      red_q          <= flash_on ? FLASH_RED : scaled_rgb[23:16];
      green_q        <= scaled_rgb[15:8];
      blue_q         <= scaled_rgb[7:0];
    end
  end

  assign redOut      = red_q;
  assign greenOut    = green_q;
  assign blueOut     = blue_q;
  assign fadeBusy    = (state_q != IDLE);
  assign screenBlack = screen_black_q;

endmodule

// File: tb/tb_screen_fade_fx.sv
// Directed bench for screen_fade_fx: reset, pixel expansion, fade timing,
// hit flash and mid-fade reset, with hand-computed expected values.
module tb_screen_fade_fx;

  logic       clk = 1'b0;
  logic       resetN = 1'b0;
  logic       startOfFrame = 1'b0;
  logic       fadeRequest = 1'b0;
  logic       hitFlash = 1'b0;
  logic [7:0] pixelRGB = 8'h00;
  logic [7:0] redOut, greenOut, blueOut;
  logic       fadeBusy, screenBlack;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  screen_fade_fx dut (
    .clk          (clk),
    .resetN       (resetN),
    .startOfFrame (startOfFrame),
    .fadeRequest  (fadeRequest),
    .hitFlash     (hitFlash),
    .pixelRGB     (pixelRGB),
    .redOut       (redOut),
    .greenOut     (greenOut),
    .blueOut      (blueOut),
    .fadeBusy     (fadeBusy),
    .screenBlack  (screenBlack)
  );

  // One frame: a single-cycle startOfFrame then one quiet cycle.
  // Returns how many sampled cycles showed screenBlack high.
  task automatic pulse_sof(output int sb_seen);
    sb_seen = 0;
    startOfFrame = 1'b1;
    @(negedge clk);
    sb_seen += int'(screenBlack);
    startOfFrame = 1'b0;
    @(negedge clk);
    sb_seen += int'(screenBlack);
  endtask

  task automatic test_reset();
    pixelRGB = 8'hFF;
    resetN = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({redOut, greenOut, blueOut, fadeBusy, screenBlack} !== 26'd0) begin
      $display("FAIL reset_outputs: got %h/%h/%h busy=%b sb=%b, want all 0",
               redOut, greenOut, blueOut, fadeBusy, screenBlack);
      n_bad++;
    end
    resetN = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({redOut, greenOut, blueOut} !== 24'hFFFFFF) begin
      $display("FAIL reset_release_pixel: got %h/%h/%h, want ff/ff/ff", redOut, greenOut, blueOut);
      n_bad++;
    end
    $display("test_reset: out=%h/%h/%h", redOut, greenOut, blueOut);
  endtask

  task automatic test_pixel_path();
    logic [7:0] pix [2];
    logic [23:0] exp_rgb [2];
    pix[0] = 8'b100_010_01; exp_rgb[0] = 24'h80_40_7F;
    pix[1] = 8'b011_101_10; exp_rgb[1] = 24'h7F_BF_80;
    for (int i = 0; i < 2; i++) begin
      pixelRGB = pix[i];
      #1;
      n_cmp++;
      if ({redOut, greenOut, blueOut} === exp_rgb[i]) begin
        $display("FAIL pixel_latency: got %h%h%h before clock edge, want previous pixel", redOut, greenOut, blueOut);
        n_bad++;
      end
      @(negedge clk);
      n_cmp++;
      if ({redOut, greenOut, blueOut} !== exp_rgb[i]) begin
        $display("FAIL pixel_expand[%0d]: got %h%h%h, want %h", i, redOut, greenOut, blueOut, exp_rgb[i]);
        n_bad++;
      end
      $display("test_pixel_path: pix=%b out=%h/%h/%h", pix[i], redOut, greenOut, blueOut);
    end
  endtask

  task automatic test_fade_steps();
    int sb;
    int sb_total;
    pixelRGB = 8'hFF;
    fadeRequest = 1'b1;
    @(negedge clk);
    fadeRequest = 1'b0;
    n_cmp++;
    if (fadeBusy !== 1'b1) begin
      $display("FAIL fade_busy_start: got %b, want 1", fadeBusy);
      n_bad++;
    end
    sb_total = 0;
    for (int n = 1; n <= 16; n++) begin
      pulse_sof(sb);
      sb_total += sb;
    end
    n_cmp++;
    if ({redOut, greenOut, blueOut} !== 24'h7F7F7F) begin
      $display("FAIL fade_level8: got %h/%h/%h, want 7f/7f/7f", redOut, greenOut, blueOut);
      n_bad++;
    end
    for (int n = 17; n <= 31; n++) begin
      pulse_sof(sb);
      sb_total += sb;
    end
    n_cmp++;
    if (sb_total !== 0) begin
      $display("FAIL fade_early_black: got %0d screenBlack cycles before frame 32, want 0", sb_total);
      n_bad++;
    end
    pulse_sof(sb);
    n_cmp++;
    if (sb !== 1) begin
      $display("FAIL fade_black_pulse: got %0d screenBlack cycles at frame 32, want 1", sb);
      n_bad++;
    end
    n_cmp++;
    if ({redOut, greenOut, blueOut} !== 24'h000000) begin
      $display("FAIL fade_black_out: got %h/%h/%h, want 0/0/0", redOut, greenOut, blueOut);
      n_bad++;
    end
    $display("test_fade_steps: frame32 sb=%0d out=%h/%h/%h", sb, redOut, greenOut, blueOut);
    for (int n = 33; n <= 94; n++) pulse_sof(sb);
    n_cmp++;
    if ({fadeBusy, redOut, greenOut, blueOut} !== {1'b0, 24'hFFFFFF}) begin
      $display("FAIL fade_return: got busy=%b out=%h/%h/%h, want 0 ff/ff/ff",
               fadeBusy, redOut, greenOut, blueOut);
      n_bad++;
    end
  endtask

  task automatic test_back_to_back();
    int sb;
    int sb_total;
    int frames;
    // Request coincides with a frame start; that frame must not count.
    fadeRequest = 1'b1;
    startOfFrame = 1'b1;
    @(negedge clk);
    fadeRequest = 1'b0;
    startOfFrame = 1'b0;
    @(negedge clk);
    frames = 0;
    sb_total = 0;
    for (int n = 1; n <= 120; n++) begin
      if (n == 20 || n == 50) fadeRequest = 1'b1;
      pulse_sof(sb);
      fadeRequest = 1'b0;
      sb_total += sb;
      if (!fadeBusy) begin
        frames = n;
        break;
      end
    end
    n_cmp++;
    if (frames !== 94) begin
      $display("FAIL busy_length: busy dropped after %0d frames, want 94", frames);
      n_bad++;
    end
    n_cmp++;
    if (sb_total !== 1) begin
      $display("FAIL busy_black_count: got %0d screenBlack cycles, want 1", sb_total);
      n_bad++;
    end
    $display("test_back_to_back: frames=%0d sb=%0d", frames, sb_total);
  endtask

  task automatic test_flash();
    int sb;
    logic [7:0] exp_r;
    pixelRGB = 8'h00;
    hitFlash = 1'b1;
    @(negedge clk);
    hitFlash = 1'b0;
    @(negedge clk);
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) pulse_sof(sb);
      exp_r = (k < 8 && ((8 - k) % 2 == 1)) ? 8'hFF : 8'h00;
      n_cmp++;
      if ({redOut, greenOut, blueOut} !== {exp_r, 16'h0000}) begin
        $display("FAIL flash_frame[%0d]: got %h/%h/%h, want %h/00/00", k, redOut, greenOut, blueOut, exp_r);
        n_bad++;
      end
    end
    $display("test_flash: single flash done, red=%h", redOut);
    hitFlash = 1'b1;
    @(negedge clk);
    hitFlash = 1'b0;
    for (int k = 1; k <= 4; k++) pulse_sof(sb);
    // Retrigger on the same cycle as frame 5: reload to 8, not decrement to 3.
    hitFlash = 1'b1;
    pulse_sof(sb);
    hitFlash = 1'b0;
    n_cmp++;
    if (redOut !== 8'h00) begin
      $display("FAIL flash_retrigger_load: got red=%h, want 00", redOut);
      n_bad++;
    end
    for (int k = 1; k <= 7; k++) pulse_sof(sb);
    n_cmp++;
    if (redOut !== 8'hFF) begin
      $display("FAIL flash_retrigger_last: got red=%h, want ff", redOut);
      n_bad++;
    end
    pulse_sof(sb);
    n_cmp++;
    if (redOut !== 8'h00) begin
      $display("FAIL flash_retrigger_end: got red=%h, want 00", redOut);
      n_bad++;
    end
    $display("test_flash: retrigger done, red=%h", redOut);
  endtask

  task automatic test_reset_mid_fade();
    int sb;
    int sb_total;
    pixelRGB = 8'hFF;
    fadeRequest = 1'b1;
    @(negedge clk);
    fadeRequest = 1'b0;
    for (int n = 1; n <= 22; n++) pulse_sof(sb);
    n_cmp++;
    if ({redOut, greenOut, blueOut} !== 24'h4F4F4F) begin
      $display("FAIL fade_level5: got %h/%h/%h, want 4f/4f/4f", redOut, greenOut, blueOut);
      n_bad++;
    end
    #2 resetN = 1'b0;
    #1;
    n_cmp++;
    if ({redOut, greenOut, blueOut, fadeBusy} !== 25'd0) begin
      $display("FAIL async_reset: got %h/%h/%h busy=%b, want 0", redOut, greenOut, blueOut, fadeBusy);
      n_bad++;
    end
    @(negedge clk);
    resetN = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({fadeBusy, screenBlack, redOut, greenOut, blueOut} !== {2'b00, 24'hFFFFFF}) begin
      $display("FAIL reset_recover: got busy=%b sb=%b out=%h/%h/%h, want 0 0 ff/ff/ff",
               fadeBusy, screenBlack, redOut, greenOut, blueOut);
      n_bad++;
    end
    sb_total = 0;
    for (int n = 1; n <= 40; n++) begin
      pulse_sof(sb);
      sb_total += sb + int'(fadeBusy);
    end
    n_cmp++;
    if (sb_total !== 0) begin
      $display("FAIL reset_idle_quiet: got %0d busy/black cycles, want 0", sb_total);
      n_bad++;
    end
    $display("test_reset_mid_fade: out=%h/%h/%h busy=%b", redOut, greenOut, blueOut, fadeBusy);
  endtask

  initial begin
    test_reset();
    test_pixel_path();
    test_fade_steps();
    test_back_to_back();
    test_flash();
    test_reset_mid_fade();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
